rng_arbiter: RTL

Controller that owns the game's single 8-bit LFSR random source and shares it among NREQ requesters, e.g. enemy spawn, item drop and screen-position logic. It drives the LFSR enable and holds it off until the game runs, then warms it up past the low-entropy start sequence. Requests are served round-robin. Each requester receives one value bounded by its own inclusive limit, using rejection sampling with a timeout fallback. It enforces a minimum gap between grants so consecutive values are decorrelated.

---
 rtl/rng_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rng_arbiter.sv
// Shares one 8-bit LFSR among NREQ requesters: holds it off until the game runs,
// warms it up, then serves bounded draws round-robin with a gap between grants.

module rng_arb_lane (
  input  logic [7:0] lfsr_out,
  input  logic [7:0] limit,
  output logic       fits,
  output logic [7:0] folded
);
  assign fits   = (lfsr_out <= limit);
  // Masking can only clear bits, so the fallback value never exceeds the limit.
  assign folded = lfsr_out & limit;
endmodule

module rng_arbiter #(
  parameter int NREQ    = 4,
  parameter int GAP     = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic              lfsr_enable,
  input  logic [7:0]        lfsr_out,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] limit,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        rnd,
  output logic              fallback,
  output logic              busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
  localparam logic [7:0] ATT_MAX  = 8'(TIMEOUT);

  typedef enum logic [2:0] {OFF, WARM, IDLE, DRAW, COOL} state_t;

  typedef struct packed {
    logic [NREQ-1:0] grant;
    logic [7:0]      rnd;
    logic            fallback;
  } rsp_t;

  state_t               state, state_nx;
  rsp_t                 rsp, rsp_nx;
  logic [7:0]           cnt, cnt_nx;
  logic [7:0]           att, att_nx;
  logic [PW-1:0]        ptr, ptr_nx;
  logic [PW-1:0]        sel, sel_nx;
  logic [NREQ-1:0]      fits;
  logic [NREQ-1:0][7:0] folded;
  logic                 pick_ok;
  logic [PW-1:0]        pick, cand;
  int                   idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    rng_arb_lane u_lane (
      .lfsr_out (lfsr_out),
      .limit    (limit[8*i +: 8]),
      .fits     (fits[i]),
      .folded   (folded[i])
    );
  end

  // Scan from farthest to nearest so the requester right after ptr wins.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    idx     = 0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = PW'(idx);
      if (req[cand]) begin
        pick_ok = 1'b1;
        pick    = cand;
      end
    end
  end

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    att_nx          = att;
    ptr_nx          = ptr;
    sel_nx          = sel;
    rsp_nx          = rsp;
    rsp_nx.grant    = '0;
    rsp_nx.fallback = 1'b0;
    if (!run) begin
      state_nx = OFF;
    end else begin
      case (state)
        OFF: begin
          state_nx = WARM;
          cnt_nx   = '0;
        end
        WARM: begin
          if (cnt == GAP_LAST) state_nx = IDLE;
          else                 cnt_nx   = cnt + 8'd1;
        end
        IDLE: begin
          if (pick_ok) begin
            sel_nx   = pick;
            att_nx   = 8'd1;
            state_nx = DRAW;
          end
        end
        DRAW: begin
          if (!req[sel]) begin
            state_nx = IDLE;
          end else if (fits[sel] || (att == ATT_MAX)) begin
            rsp_nx.grant[sel] = 1'b1;
            rsp_nx.rnd        = fits[sel] ? lfsr_out : folded[sel];
            rsp_nx.fallback   = !fits[sel];
            ptr_nx            = sel;
            cnt_nx            = '0;
            state_nx          = COOL;
          end else begin
            att_nx = att + 8'd1;
          end
        end
        COOL: begin
          // The gap ends straight into the next draw when someone is waiting.
          if (cnt == GAP_LAST) begin
            if (pick_ok) begin
              sel_nx   = pick;
              att_nx   = 8'd1;
              state_nx = DRAW;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
        default: state_nx = OFF;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= OFF;
      rsp         <= '0;
      cnt         <= '0;
      att         <= '0;
      ptr         <= PW'(NREQ - 1);
      sel         <= '0;
      lfsr_enable <= 1'b0;
    end else begin
      state       <= state_nx;
      rsp         <= rsp_nx;
      cnt         <= cnt_nx;
      att         <= att_nx;
      ptr         <= ptr_nx;
      sel         <= sel_nx;
      lfsr_enable <= run;
    end
  end

  assign grant    = rsp.grant;
  assign rnd      = rsp.rnd;
  assign fallback = rsp.fallback;
  assign busy     = (state == WARM) || (state == DRAW) || (state == COOL);
endmodule
